// File: rtl/ifetch_queue.sv
// Instruction fetch unit: issues one memory request at a time from fetch_pc and
// buffers returned words with their addresses in a small FIFO for decode.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h00003000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic [31:0] fetch_pc
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e            state_q;
  logic [31:0]       fetch_q;
  logic [31:0]       addr_q;
  logic [PtrW-1:0]   rd_q;
  logic [PtrW-1:0]   wr_q;
  logic [CntW-1:0]   cnt_q;
  logic [63:0]       mem_q [DEPTH];

  logic push, pop, issue;
  logic unused_rpc;

  // Target is word-aligned on redirect, so the low bits are never used.
  assign unused_rpc = ^redirect_pc[1:0];

  always_comb begin
    push  = (state_q == StWait) && im_ack && !redirect;
    pop   = instr_valid && instr_ready && !redirect;
    issue = (state_q == StIdle) && !redirect && (cnt_q < CntW'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      fetch_q <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      case (state_q)
        StIdle: begin
          if (issue) begin
            state_q <= StWait;
            addr_q  <= fetch_q;
          end
        end
        StWait: begin
          if (im_ack) begin
            state_q <= StIdle;
          end else if (redirect) begin
            state_q <= StDrop;
          end
        end
        StDrop: begin
          if (im_ack) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (redirect) begin
        fetch_q <= {redirect_pc[31:2], 2'b00};
      end else if (push) begin
        fetch_q <= fetch_q + 32'd4;
      end
    end
  end

  // Redirect flushes the queue and overrides any push or pop in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (redirect) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PtrW'(1);
      if (pop)  rd_q <= rd_q + PtrW'(1);
      cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= {fetch_q, im_data};
    end
  end

  always_comb begin
    im_req      = (state_q != StIdle);
    im_addr     = addr_q;
    fetch_pc    = fetch_q;
    instr_valid = (cnt_q != '0);
    {instr_pc, instr} = instr_valid ? mem_q[rd_q] : 64'd0;
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue: queue-based reference model plus a
// scoreboard monitor that checks every instruction handed to decode.
module tb_ifetch_queue;

  localparam logic [31:0] RPC = 32'h00003000;
  localparam int          D   = 4;

  logic        clk, reset_n, redirect, im_req, im_ack, instr_valid, instr_ready;
  logic [31:0] redirect_pc, im_addr, im_data, instr, instr_pc, fetch_pc;

  ifetch_queue #(.RESET_PC(RPC), .DEPTH(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_ack     (im_ack),
    .im_data    (im_data),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready),
    .fetch_pc   (fetch_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];     // model queue contents
  ent_t        exp_q[$];  // scoreboard of words decode should receive
  int          outst;     // 0 none, 1 live request, 2 stale request
  logic [31:0] m_fetch, m_addr;
  int          n_pass, n_total;
  bit          reset_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    outst   = 0;
    m_fetch = RPC;
    m_addr  = RPC;
  endtask

  task automatic model_step();
    bit   can_issue;
    ent_t e;
    can_issue = (mq.size() < D);
    if (mq.size() != 0 && instr_ready && !redirect) void'(mq.pop_front());
    case (outst)
      0: if (!redirect && can_issue) begin
        outst  = 1;
        m_addr = m_fetch;
      end
      1: if (im_ack) begin
        if (!redirect) begin
          e = '{pc: m_fetch, data: im_data};
          mq.push_back(e);
          exp_q.push_back(e);
          m_fetch = m_fetch + 32'd4;
        end
        outst = 0;
      end else if (redirect) begin
        outst = 2;
      end
      default: if (im_ack) outst = 0;
    endcase
    if (redirect) begin
      m_fetch = {redirect_pc[31:2], 2'b00};
      mq.delete();
      exp_q.delete();
    end
  endtask

  task automatic check_outputs();
    check("im_req", 32'(im_req), 32'(outst != 0));
    check("im_addr", im_addr, m_addr);
    check("fetch_pc", fetch_pc, m_fetch);
    check("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
    if (mq.size() == 0) begin
      check("instr_empty", instr, 32'd0);
      check("instr_pc_empty", instr_pc, 32'd0);
    end else begin
      check("head_pc", instr_pc, mq[0].pc);
      check("head_data", instr, mq[0].data);
    end
  endtask

  task automatic drive(input int rdy_pct, input int rdr_pct, input int ack_pct);
    instr_ready = ($urandom_range(99) < rdy_pct);
    redirect    = ($urandom_range(99) < rdr_pct);
    case ($urandom_range(3))
      0:       redirect_pc = 32'hFFFF_FFFF;
      1:       redirect_pc = 32'h0000_3403;
      default: redirect_pc = $urandom;
    endcase
    if (outst != 0) im_ack = ($urandom_range(99) < ack_pct);
    else            im_ack = ($urandom_range(99) < 10);
    im_data = $urandom;
  endtask

  // Scoreboard monitor: every handshake to decode must match the next expected word.
  always @(negedge clk) begin : monitor
    ent_t e;
    if (reset_n && instr_valid && instr_ready && !redirect) begin
      check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pop_pc", instr_pc, e.pc);
        check("pop_data", instr, e.data);
      end
    end
  end

  int rdy_tab[4] = '{100, 0, 60, 50};
  int rdr_tab[4] = '{0, 0, 8, 15};
  int ack_tab[4] = '{100, 80, 40, 60};

  initial begin
    clk = 0; reset_n = 1; redirect = 0; redirect_pc = 0; im_ack = 0; im_data = 0;
    instr_ready = 0; n_pass = 0; n_total = 0; reset_done = 0;
    model_reset();
    #1 reset_n = 0;
    #2 check_outputs();
    @(posedge clk); #1 reset_n = 1;

    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 500; c++) begin
        @(negedge clk); #1;
        check_outputs();
        model_step();
        @(posedge clk); #1;
        if (p == 1 && c >= 100) drive(70, 0, 80);
        else                    drive(rdy_tab[p], rdr_tab[p], ack_tab[p]);
        if (p == 2 && c >= 100 && !reset_done && outst == 1) begin
          #1 reset_n = 0;
          #1;
          check("rst_im_req", 32'(im_req), 32'd0);
          check("rst_valid", 32'(instr_valid), 32'd0);
          check("rst_fetch_pc", fetch_pc, RPC);
          check("rst_im_addr", im_addr, RPC);
          check("rst_instr", instr, 32'd0);
          check("rst_instr_pc", instr_pc, 32'd0);
          model_reset();
          @(posedge clk); #1;
          reset_n  = 1;
          redirect = 0;
          im_ack   = 1;
          reset_done = 1;
        end
      end
    end
    check("reset_exercised", 32'(reset_done), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00003000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, instruction queue entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port redirect  input  1  branch/jump redirect request from the PC-select logic.
REQ-006 SHALL have port redirect_pc  input  32  redirect target address.
REQ-007 SHALL have port im_req  output  1  instruction memory request valid.
REQ-008 SHALL have port im_addr  output  32  instruction memory request address.
REQ-009 SHALL have port im_ack  input  1  memory response valid; completes the outstanding request.
REQ-010 SHALL have port im_data  input  32  instruction word, valid when im_ack=1.
REQ-011 SHALL have port instr_valid  output  1  queue head holds a valid instruction.
REQ-012 SHALL have port instr  output  32  queue head instruction word.
REQ-013 SHALL have port instr_pc  output  32  address of queue head instruction.
REQ-014 SHALL have port instr_ready  input  1  decode consumes head when instr_valid=1.
REQ-015 SHALL have port fetch_pc  output  32  address of the next request to be issued.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, DROP; im_req=1 exactly in WAIT and DROP.
REQ-017 SHALL allow at most one outstanding memory request.
REQ-018 SHALL hold im_addr stable from im_req rise until the cycle im_ack=1.
REQ-019 IDLE: redirect=0 and count<DEPTH -> WAIT, im_addr<=fetch_pc; otherwise stay IDLE.
REQ-020 WAIT, im_ack=1, redirect=0: push {fetch_pc, im_data}, fetch_pc<=fetch_pc+4, -> IDLE.
REQ-021 WAIT, redirect=1: im_ack=1 -> discard data, -> IDLE; im_ack=0 -> DROP.
REQ-022 DROP: im_ack=1 -> discard data, -> IDLE; im_ack=0 -> stay DROP.
REQ-023 Any state, redirect=1: fetch_pc<={redirect_pc[31:2],2'b00}, queue flushed, redirect overrides pop and push in that cycle.
REQ-024 Redirect in DROP SHALL update fetch_pc again and remain in DROP.
REQ-025 fetch_pc+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 0).
REQ-026 Pop when instr_valid=1 and instr_ready=1; instr_ready with empty queue SHALL be ignored.
REQ-027 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-028 Issue gating (count<DEPTH in IDLE) SHALL guarantee no push to a full queue.
REQ-029 instr_valid = (count!=0); instr and instr_pc SHALL read 0 when queue empty.
REQ-030 Minimum latency: IDLE->im_req 1 cycle; im_ack at edge N -> instr_valid=1 after edge N.
REQ-031 im_ack in IDLE (spurious) SHALL be ignored.

Reset
REQ-032 reset_n=0 SHALL immediately force state IDLE, count 0, im_req=0, instr_valid=0, instr=0, instr_pc=0, fetch_pc=RESET_PC, im_addr=RESET_PC.
REQ-033 Reset during WAIT/DROP SHALL abandon the outstanding request; a later im_ack SHALL be treated as spurious.

Verification
REQ-034 Reset release, im_ack one cycle after each im_req, instr_ready=1 -> instr_pc sequence 0x3000, 0x3004, 0x3008, instr matching im_data.
REQ-035 instr_ready=0, memory always acks -> exactly DEPTH=4 entries queued, im_req stays 0, fetch_pc=0x3010.
REQ-036 Redirect to 0x3403 while WAIT with im_ack=0, ack 3 cycles later -> ack data dropped, next im_addr=0x3400, queue empty until 0x3400 returns.
REQ-037 Redirect with queue full and instr_ready=1 same cycle -> instr_valid=0 next cycle, no pop observed downstream.
REQ-038 Redirect to 0xFFFFFFFC, two acks -> instr_pc 0xFFFFFFFC then 0x00000000.
REQ-039 reset_n low mid-WAIT, then im_ack after release -> ack ignored, first im_addr=RESET_PC.
